fa4_serial: RTL and testbench
=============================

FA4_SERIAL -- requirements
Module: fa4_serial

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled on a rising clk edge, accepted only when busy=0.
REQ-005 a  input  WIDTH  operand A; sampled on the acceptance edge only.
REQ-006 b  input  WIDTH  operand B; sampled on the acceptance edge only.
REQ-007 ci  input  1  carry-in; sampled on the acceptance edge only.
REQ-008 s  output  WIDTH  registered sum of the last completed operation.
REQ-009 co  output  1  registered carry-out of the last completed operation.
REQ-010 busy  output  1  high while an operation is in progress (state CALC).
REQ-011 done  output  1  single-cycle pulse when s and co update.

Function
REQ-012 The block SHALL compute {co,s} = a + b + ci bit-serially, LSB first, one bit per clock.
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE with start=1 -> CALC. On that edge, latch a, b and ci into internal shift and carry registers, and clear the bit counter.
REQ-015 CALC: on each edge, add operand bit 0 and the carry, shift the sum bit into the result MSB, shift the operands right, update the carry, and increment the counter.
REQ-016 CALC -> DONE on the edge that processes bit WIDTH-1. On that same edge, load s and co from the result and carry, and raise done.
REQ-017 DONE with start=0 -> IDLE. DONE with start=1 -> CALC, with a new operand load per REQ-014, giving back-to-back operation.
REQ-018 Latency: if start is accepted at edge N, done is high and s/co are valid from edge N+WIDTH to edge N+WIDTH+1.
REQ-019 Throughput: at most one operation per WIDTH+1 cycles.
REQ-020 busy=1 exactly while in CALC; done=1 exactly while in DONE.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 Changes on a, b or ci after the acceptance edge SHALL NOT affect the result.
REQ-023 s and co SHALL hold their values between completions. They change only on the REQ-016 edge.
REQ-024 Arithmetic is modulo 2^WIDTH in s, and the carry out of bit WIDTH-1 appears in co. All-ones + all-ones + 1 gives s = all-ones, co = 1.
REQ-025 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 When rst_n=0, asynchronously: state=IDLE, s=0, co=0, busy=0, done=0, counter=0, internal registers=0.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; no done pulse follows.
REQ-028 After rst_n rises, the first start is accepted on the next edge.

Structure
REQ-029 State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH SHALL live in a shared package/include file for reuse by the bench.
REQ-030 The single-bit add SHALL be one instance of sub-module fa (s, co, a, b, ci), the same 1-bit full adder used by the ripple adders. No '+' operator is allowed in the datapath.
REQ-031 Control (FSM and counter) and datapath (shift registers and carry) SHALL be separate always blocks within fa4_serial.

Verification
REQ-032 The bench SHALL cover the following directed scenarios at WIDTH=4; every result is also checked against a+b+ci.
- V1: a=7, b=5, ci=0, start at edge N -> done at edge N+4, s=12, co=0; busy high for 4 cycles.
- V2: a=15, b=1, ci=0 -> s=0, co=1. Then a=15, b=15, ci=1 -> s=15, co=1.
- V3: a=3, b=4, ci=1 accepted; at edge N+2, start=1 with a=9 and b=9 -> ignored; result is s=8, co=0 with exactly one done pulse.
- V4: two operations back-to-back with start held high through DONE (2+2+0, then 8+8+0) -> s=4, co=0, then s=0, co=1. Done pulses are 5 cycles apart.
- V5: rst_n low at edge N+2 of an operation -> s=0, co=0, busy=0, no done. A new request 1+1+0 after release -> s=2, co=0.
- V6: ten $random {ci,a,b} vectors -> each result matches a+b+ci, and matches the combinational ripple adders driven with the same vectors.

Source files
------------

// File: rtl/fa4_serial_pkg.sv
// fa4_serial_pkg: shared state encodings and default width for the serial adder
package fa4_serial_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fa4_serial_fa.sv
// fa: 1-bit full adder, the same cell used by the ripple adders
module fa (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/fa4_serial.sv
// fa4_serial: bit-serial adder, one full-adder bit per clock, LSB first
module fa4_serial
  import fa4_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, res;
  logic c, sum, cout, load, last;
  fa u_fa (.s(sum), .co(cout), .a(ra[0]), .b(rb[0]), .ci(c));
  assign busy = state == CALC;
  assign done = state == DONE;
  assign load = start && !busy;
  assign last = busy && cnt == CW'(WIDTH - 1);
  // state register and bit counter; counter parks on the last bit instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= load ? '0 : (busy && !last) ? cnt + CW'(1) : cnt;
    end
  // next state: a request wins from IDLE or DONE, CALC ends on the last bit
  always_comb nxt = load ? CALC : last ? DONE : done ? IDLE : state;
  // datapath: operand shifters, running carry, result shifter and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      res <= '0;
      c   <= 1'b0;
      s   <= '0;
      co  <= 1'b0;
    end else if (load) begin
      ra <= a;
      rb <= b;
      c  <= ci;
    end else if (busy) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      res <= {sum, res[WIDTH-1:1]};
      c   <= cout;
      if (last) begin
        s  <= {sum, res[WIDTH-1:1]};
        co <= cout;
      end
    end
endmodule

// File: tb/tb_fa4_serial.sv
// tb_fa4_serial: directed scoreboard bench for the bit-serial adder
module tb_fa4_serial;
  import fa4_serial_pkg::*;
  localparam int W = DEF_WIDTH;
  logic clk = 0, rst_n = 0, start = 0, ci = 0, co, busy, done;
  logic [W-1:0] a = '0, b = '0, s;
  logic [W-1:0] ra = '0, rb = '0, rs;
  logic rci = 0;
  logic [W:0] rc;
  logic [W:0] exp_q[$];
  logic [W:0] e;
  int nc = 0, nf = 0, cyc = 0, dn = 0;

  fa4_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
    .s(s), .co(co), .busy(busy), .done(done)
  );

  assign rc[0] = rci;
  for (genvar g = 0; g < W; g++) begin : g_rip
    fa u (.s(rs[g]), .co(rc[g+1]), .a(ra[g]), .b(rb[g]), .ci(rc[g]));
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nc++;
    assert (obs === want) else begin
      nf++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic logic [W:0] sum_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
    logic [W:0] cz;
    cz = '0;
    cz[0] = z;
    return {1'b0, x} + {1'b0, y} + cz;
  endfunction

  // scoreboard: every done pulse pops one expected {co,s}
  always @(negedge clk) if (done) begin
    dn++;
    chk("queue_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result", {co, s}, e);
    end
  end

  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y, input logic z, input bit push);
    a = x;
    b = y;
    ci = z;
    start = 1;
    if (push) exp_q.push_back(sum_of(x, y, z));
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int bn, output int at);
    bit f;
    f = 0;
    bn = 0;
    at = 0;
    for (int i = 0; i < 40 && !f; i++) begin
      if (done) begin
        f = 1;
        at = cyc;
      end else begin
        bn += int'(busy);
        @(negedge clk);
      end
    end
    chk("done_seen", f, 1);
  endtask

  initial begin
    int bn, d1, d2, d0;
    logic [W-1:0] x, y;
    logic z;
    repeat (2) @(negedge clk);
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    // V1: 7+5+0, busy for exactly WIDTH cycles, result holds afterwards
    go(7, 5, 0, 1);
    wait_done(bn, d1);
    chk("v1_busy_cycles", bn, W);
    @(negedge clk);
    chk("v1_done_single", done, 0);
    chk("v1_s_hold", s, 12);
    chk("v1_co_hold", co, 0);
    // V2: wrap and all-ones corner
    go(15, 1, 0, 1);
    wait_done(bn, d1);
    @(negedge clk);
    go(15, 15, 1, 1);
    wait_done(bn, d1);
    @(negedge clk);
    // V3: start while busy is ignored, operands changed mid-flight
    d0 = dn;
    go(3, 4, 1, 1);
    @(negedge clk);
    a = 9;
    b = 9;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done(bn, d1);
    repeat (6) @(negedge clk);
    chk("v3_one_done", dn - d0, 1);
    chk("v3_s", s, 8);
    // V4: back-to-back with start held through DONE
    a = 2;
    b = 2;
    ci = 0;
    start = 1;
    exp_q.push_back(sum_of(2, 2, 0));
    @(negedge clk);
    a = 8;
    b = 8;
    exp_q.push_back(sum_of(8, 8, 0));
    wait_done(bn, d1);
    @(negedge clk);
    start = 0;
    wait_done(bn, d2);
    chk("v4_done_spacing", d2 - d1, W + 1);
    chk("v4_co", co, 1);
    @(negedge clk);
    // V5: reset mid-operation aborts it
    d0 = dn;
    go(7, 6, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("v5_s", s, 0);
    chk("v5_co", co, 0);
    chk("v5_busy", busy, 0);
    chk("v5_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("v5_no_done", dn - d0, 0);
    go(1, 1, 0, 1);
    wait_done(bn, d1);
    chk("v5_busy_cycles", bn, W);
    @(negedge clk);
    // V6: random vectors, also against a combinational ripple adder
    for (int i = 0; i < 10; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      z = 1'($urandom);
      ra = x;
      rb = y;
      rci = z;
      #1;
      chk("v6_ripple", {rc[W], rs}, sum_of(x, y, z));
      go(x, y, z, 1);
      wait_done(bn, d1);
      chk("v6_vs_ripple", {co, s}, {rc[W], rs});
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
